// File: rtl/pe_share_arbiter_pkg.sv
// Purpose: shared op codes, instruction field layout, FSM states and EXEC-length helper for the PE share arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pe_share_arbiter_pkg;

  localparam int P_ADDR_W  = 6;
  localparam int P_TIMES_W = 6;
  localparam int P_OP_W    = 2;
  localparam int P_INSTR_W = 3 * P_ADDR_W + P_OP_W + P_TIMES_W;

  // Instruction layout, MSB to LSB: {dest, src1, op, times, src2}
  localparam int P_SRC2_LSB  = 0;
  localparam int P_TIMES_LSB = P_SRC2_LSB + P_ADDR_W;
  localparam int P_OP_LSB    = P_TIMES_LSB + P_TIMES_W;
  localparam int P_SRC1_LSB  = P_OP_LSB + P_OP_W;
  localparam int P_DEST_LSB  = P_SRC1_LSB + P_ADDR_W;

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_SUB   = 2'd1,
    OP_CUBIC = 2'd2,
    OP_MULT  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Number of EXEC cycles: single-shot ops take one, iterated ops take
  // 'times' with zero promoted to one so the PE always fires at least once.
  function automatic logic [P_TIMES_W-1:0] exec_len(op_t op, logic [P_TIMES_W-1:0] times);
    if (op == OP_ADD || op == OP_SUB) return P_TIMES_W'(1);
    if (times == '0) return P_TIMES_W'(1);
    return times;
  endfunction

endpackage

// File: rtl/pe_share_arbiter_pick.sv
// Purpose: 2-way round-robin winner selector between the two microcode requesters.
// Latency: combinational.
// Backpressure: none; the caller decides when the choice is consumed.
module pe_rr_pick (
  input  logic [1:0] req_valid,
  input  logic       last_winner,
  output logic       winner
);

  // Sole requester wins; on contention the one that did not go last wins.
  always_comb begin
    winner = 1'b0;
    case (req_valid)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_winner;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/pe_share_arbiter.sv
// Purpose: shares one PE/RAM datapath between two microcode requesters, round-robin.
// Latency: N EXEC cycles + 1 WRITE cycle + 1 IDLE bubble per instruction (N+2 total).
// Backpressure: a requester holds valid/instr until its one-cycle ack; the loser simply waits.
module pe_share_arbiter
  import pe_share_arbiter_pkg::*;
#(
  parameter int ADDR_W  = P_ADDR_W,
  parameter int TIMES_W = P_TIMES_W,
  parameter int INSTR_W = P_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  input  logic [INSTR_W-1:0] req_instr0,
  input  logic [INSTR_W-1:0] req_instr1,
  output logic [1:0]         req_ack,
  output logic [1:0]         grant,
  output logic [ADDR_W-1:0]  ram_a_addr,
  output logic [ADDR_W-1:0]  ram_b_addr,
  output logic               ram_b_w,
  output logic               pe_en,
  output logic               pe_first,
  output logic [1:0]         pe_op,
  output logic               busy
);

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q;
  logic [TIMES_W-1:0]   cnt_q;
  logic                 winner_q;
  logic                 last_winner_q;

  logic                 pick;
  logic [INSTR_W-1:0]   sel_instr;
  logic [TIMES_W-1:0]   sel_len;
  logic [TIMES_W-1:0]   cur_len;
  logic [1:0]           owner_oh;

  pe_rr_pick u_pick (
    .req_valid   (req_valid),
    .last_winner (last_winner_q),
    .winner      (pick)
  );

  assign sel_instr = pick ? req_instr1 : req_instr0;
  assign sel_len   = exec_len(op_t'(sel_instr[P_OP_LSB +: P_OP_W]), sel_instr[P_TIMES_LSB +: TIMES_W]);
  assign cur_len   = exec_len(op_t'(instr_q[P_OP_LSB +: P_OP_W]), instr_q[P_TIMES_LSB +: TIMES_W]);
  assign owner_oh  = {winner_q, ~winner_q};

  // State register; reset aborts any in-flight instruction without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: IDLE -> EXEC on any request, EXEC counts down, WRITE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|req_valid) state_d = ST_EXEC;
      ST_EXEC:  if (cnt_q == '0) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: latch winner and instruction at grant, count EXEC, record last winner at retire.
  // last_winner resets to 1 so requester 0 takes the first contended grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q       <= '0;
      cnt_q         <= '0;
      winner_q      <= 1'b0;
      last_winner_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            winner_q <= pick;
            instr_q  <= sel_instr;
            cnt_q    <= sel_len - TIMES_W'(1);
          end
        end
        ST_EXEC: begin
          if (cnt_q != '0) cnt_q <= cnt_q - TIMES_W'(1);
        end
        ST_WRITE: last_winner_q <= winner_q;
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only; IDLE drives everything low.
  always_comb begin
    req_ack    = 2'b00;
    grant      = 2'b00;
    ram_a_addr = '0;
    ram_b_addr = '0;
    ram_b_w    = 1'b0;
    pe_en      = 1'b0;
    pe_first   = 1'b0;
    pe_op      = 2'b00;
    busy       = 1'b0;
    case (state_q)
      ST_EXEC: begin
        grant      = owner_oh;
        busy       = 1'b1;
        pe_en      = 1'b1;
        pe_op      = instr_q[P_OP_LSB +: P_OP_W];
        ram_a_addr = instr_q[P_SRC1_LSB +: ADDR_W];
        ram_b_addr = instr_q[P_SRC2_LSB +: ADDR_W];
        pe_first   = (cnt_q == cur_len - TIMES_W'(1));
      end
      ST_WRITE: begin
        grant      = owner_oh;
        busy       = 1'b1;
        ram_b_addr = instr_q[P_DEST_LSB +: ADDR_W];
        ram_b_w    = 1'b1;
        req_ack    = owner_oh;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_share_arbiter.sv
module tb_pe_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [25:0] req_instr0 = '0;
  logic [25:0] req_instr1 = '0;
  logic [1:0]  req_ack, grant;
  logic [5:0]  ram_a_addr, ram_b_addr;
  logic        ram_b_w, pe_en, pe_first, busy;
  logic [1:0]  pe_op;
  logic [21:0] dut_v;

  int checks = 0;
  int failures = 0;

  pe_share_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_instr0(req_instr0), .req_instr1(req_instr1),
    .req_ack(req_ack), .grant(grant), .ram_a_addr(ram_a_addr), .ram_b_addr(ram_b_addr),
    .ram_b_w(ram_b_w), .pe_en(pe_en), .pe_first(pe_first), .pe_op(pe_op), .busy(busy)
  );

  always #5 clk = ~clk;

  assign dut_v = {req_ack, grant, ram_a_addr, ram_b_addr, ram_b_w, pe_en, pe_first, pe_op, busy};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [25:0] mk(input int d, input int s1, input int op, input int t, input int s2);
    return {d[5:0], s1[5:0], op[1:0], t[5:0], s2[5:0]};
  endfunction

  // EXEC length from the op rules: ADD/SUB once, CUBIC/MULT 'times' times (0 means 1)
  function automatic int ref_n(input logic [1:0] op, input logic [5:0] t);
    if (op < 2'd2) return 1;
    if (t == 6'd0) return 1;
    return int'(t);
  endfunction

  // ---------------- cycle-timeline reference model ----------------
  // A granted instruction occupies cycles start .. start+N-1 (EXEC), start+N (WRITE),
  // start+N+1 (idle bubble); the next grant can happen at the edge after that.
  logic        m_active = 1'b0;
  logic        m_last = 1'b1;   // requester that went last; 1 after reset gives 0 priority
  logic        m_win = 1'b0;
  logic [25:0] m_instr = '0;
  int          m_n = 0, m_start = 0, cur = 0, d;
  logic [1:0]  oh;
  logic [21:0] exp_v, mask_v;

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        cur++;
        if (!m_active) begin
          if (req_valid != 2'b00) begin
            if (req_valid == 2'b11) m_win = (m_last == 1'b1) ? 1'b0 : 1'b1;
            else                    m_win = req_valid[1];
            m_instr  = m_win ? req_instr1 : req_instr0;
            m_n      = ref_n(m_instr[13:12], m_instr[11:6]);
            m_start  = cur;
            m_active = 1'b1;
          end
        end else if (cur - m_start == m_n + 1) begin
          m_last   = m_win;
          m_active = 1'b0;
        end
      end
      @(negedge clk);
      exp_v  = '0;
      mask_v = '1;
      if (reset) begin
        m_active = 1'b0;
        m_last   = 1'b1;
      end else if (m_active) begin
        d  = cur - m_start;
        oh = m_win ? 2'b10 : 2'b01;
        if (d < m_n) begin
          exp_v = {2'b00, oh, m_instr[19:14], m_instr[5:0], 1'b0, 1'b1, (d == 0), m_instr[13:12], 1'b1};
        end else if (d == m_n) begin
          exp_v  = {oh, oh, 6'd0, m_instr[25:20], 1'b1, 1'b0, 1'b0, 2'b00, 1'b1};
          mask_v = 22'b11_11_000000_111111_1_1_1_00_1;
        end
      end
      checks++;
      if ((dut_v & mask_v) !== (exp_v & mask_v)) begin
        failures++;
        $display("FAIL cycle_model cyc=%0d actual=%h required=%h mask=%h", cur, dut_v, exp_v, mask_v);
      end
    end
  end

  // ---------------- directed helpers ----------------
  typedef struct {
    logic [1:0]  valid;
    logic [25:0] i0;
    logic [25:0] i1;
    logic [1:0]  ack;
    int          n;
    logic [5:0]  dest;
    logic [5:0]  a;
    logic [5:0]  b;
  } vec_t;

  vec_t tbl[6];

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (!busy && grant == 2'b00) begin ok = 1'b1; break; end
    end
    check("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic run_entry(input vec_t v, input int idx);
    int n_busy, n_en, n_first, n_w;
    logic [5:0] wa, fa, fb;
    logic [1:0] ackv;
    logic got;
    string tag;
    n_busy = 0; n_en = 0; n_first = 0; n_w = 0;
    wa = '0; fa = '0; fb = '0; ackv = '0; got = 1'b0;
    @(posedge clk); #1;
    req_instr0 = v.i0;
    req_instr1 = v.i1;
    req_valid  = v.valid;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (pe_en) n_en++;
      if (pe_first) begin n_first++; fa = ram_a_addr; fb = ram_b_addr; end
      if (ram_b_w) begin n_w++; wa = ram_b_addr; end
      if (req_ack != 2'b00) begin ackv = req_ack; got = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    tag = $sformatf("tbl%0d", idx);
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    check({tag, "_ack"}, 32'(ackv), 32'(v.ack));
    check({tag, "_pe_en_cycles"}, 32'(n_en), 32'(v.n));
    check({tag, "_pe_first_cycles"}, 32'(n_first), 32'd1);
    check({tag, "_write_pulses"}, 32'(n_w), 32'd1);
    check({tag, "_write_addr"}, 32'(wa), 32'(v.dest));
    check({tag, "_first_a"}, 32'(fa), 32'(v.a));
    check({tag, "_first_b"}, 32'(fb), 32'(v.b));
    check({tag, "_busy_cycles"}, 32'(n_busy), 32'(v.n + 1));
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] g[4], av[4], accum;
    int gc[4], ac[4], ng, na, cyc;
    logic [1:0] prevg;
    logic seen;
    logic [1:0] pend, ackp;

    tbl[0] = '{2'b01, mk(10, 11, 0, 1, 12), '0, 2'b01, 1, 6'd10, 6'd11, 6'd12};
    tbl[1] = '{2'b10, '0, mk(40, 41, 3, 33, 42), 2'b10, 33, 6'd40, 6'd41, 6'd42};
    tbl[2] = '{2'b01, mk(5, 6, 2, 0, 7), '0, 2'b01, 1, 6'd5, 6'd6, 6'd7};
    tbl[3] = '{2'b10, '0, mk(8, 9, 2, 5, 3), 2'b10, 5, 6'd8, 6'd9, 6'd3};
    tbl[4] = '{2'b01, mk(63, 0, 1, 9, 63), '0, 2'b01, 1, 6'd63, 6'd0, 6'd63};
    tbl[5] = '{2'b10, '0, mk(1, 2, 3, 63, 3), 2'b10, 63, 6'd1, 6'd2, 6'd3};

    #2;
    check("reset_state", 32'(dut_v), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 6; i++) run_entry(tbl[i], i);

    // Both requesters hold SUB continuously: grants alternate with one idle bubble
    do_reset();
    @(posedge clk); #1;
    req_instr0 = mk(20, 21, 1, 1, 22);
    req_instr1 = mk(20, 21, 1, 1, 22);
    req_valid  = 2'b11;
    ng = 0; na = 0; cyc = 0; prevg = 2'b00;
    for (int i = 0; i < 4; i++) begin g[i] = 2'b00; av[i] = 2'b00; gc[i] = 0; ac[i] = 0; end
    for (int k = 0; k < 60 && ng < 4; k++) begin
      @(negedge clk);
      cyc++;
      if (grant != 2'b00 && prevg == 2'b00) begin g[ng] = grant; gc[ng] = cyc; ng++; end
      if (req_ack != 2'b00 && na < 4) begin av[na] = req_ack; ac[na] = cyc; na++; end
      prevg = grant;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("alt_grant_count", 32'(ng), 32'd4);
    check("alt_grant0", 32'(g[0]), 32'h1);
    check("alt_grant1", 32'(g[1]), 32'h2);
    check("alt_grant2", 32'(g[2]), 32'h1);
    check("alt_grant3", 32'(g[3]), 32'h2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("alt_ack%0d_owner", k), 32'(av[k]), 32'(g[k]));
      check($sformatf("alt_ack%0d_to_next_grant", k), 32'(gc[k+1] - ac[k]), 32'd2);
    end
    wait_idle();

    // Reset in EXEC cycle 3 of a MULT x33 won by requester 1
    do_reset();
    run_entry(tbl[0], 6);
    @(posedge clk); #1;
    req_instr0 = mk(10, 11, 0, 1, 12);
    req_instr1 = mk(40, 41, 3, 33, 42);
    req_valid  = 2'b11;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pe_first) begin seen = 1'b1; break; end
    end
    check("rst_exec_started", 32'(seen), 32'd1);
    check("rst_pre_grant", 32'(grant), 32'h2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1 check("rst_outputs_zero", 32'(dut_v), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    accum = 2'b00;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      accum |= req_ack;
      if (grant != 2'b00) begin seen = 1'b1; break; end
    end
    check("rst_regrant_seen", 32'(seen), 32'd1);
    check("rst_regrant_req0", 32'(grant), 32'h1);
    check("rst_no_ack", 32'(accum), 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();

    // req0 withdraws before the grant edge; req1 takes the datapath
    do_reset();
    @(posedge clk); #1;
    req_instr1 = mk(1, 2, 3, 4, 3);
    req_valid  = 2'b10;
    accum = 2'b00;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (grant == 2'b10) begin seen = 1'b1; break; end
    end
    check("wd_first_grant", 32'(seen), 32'd1);
    @(posedge clk); #1;
    req_instr0 = mk(7, 8, 0, 1, 9);
    req_valid  = 2'b11;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      accum |= req_ack;
      if (req_ack != 2'b00) begin seen = 1'b1; break; end
    end
    check("wd_first_ack", 32'(accum), 32'h2);
    @(posedge clk); #1;
    req_instr1 = mk(4, 5, 1, 1, 6);
    req_valid  = 2'b10;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      accum |= req_ack;
      if (grant != 2'b00) begin seen = 1'b1; break; end
    end
    check("wd_second_grant", 32'(grant), 32'h2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      accum |= req_ack;
      if (req_ack != 2'b00) break;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("wd_req0_no_ack", 32'(accum[0]), 32'd0);
    wait_idle();

    // Randomised requesters obeying the hold-until-ack contract; model checks every cycle
    do_reset();
    pend = 2'b00;
    ackp = 2'b00;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      ackp = req_ack;
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (ackp[r]) pend[r] = 1'b0;
        if (!pend[r] && ($urandom % 3) == 0) begin
          logic [25:0] ins;
          int t;
          t = (($urandom % 8) == 0) ? int'($urandom % 64) : int'($urandom % 8);
          ins = mk(int'($urandom % 64), int'($urandom % 64), int'($urandom % 4), t, int'($urandom % 64));
          if (r == 0) req_instr0 = ins; else req_instr1 = ins;
          pend[r] = 1'b1;
        end
      end
      req_valid = pend;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
